// File: rtl/uart_move_tx_pkg.sv
// Move-packet definitions shared by the transmitter and the rx-side parser:
// framing bytes, packet length, byte positions and the checksum rule.
package uart_move_tx_pkg;

  localparam logic [7:0] MOVE_SOF_BYTE  = 8'hA5;
  localparam logic [7:0] MOVE_PASS_BYTE = 8'hFF;
  localparam int         MOVE_COORD_W   = 5;

  localparam logic [2:0] PKT_LEN   = 3'd5;
  localparam logic [2:0] IDX_SOF   = 3'd0;
  localparam logic [2:0] IDX_PIECE = 3'd1;
  localparam logic [2:0] IDX_X     = 3'd2;
  localparam logic [2:0] IDX_Y     = 3'd3;
  localparam logic [2:0] IDX_CHK   = PKT_LEN - 3'd1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

  function automatic logic [7:0] pkt_checksum(input logic [7:0] b1,
                                              input logic [7:0] b2,
                                              input logic [7:0] b3);
    return b1 ^ b2 ^ b3;
  endfunction

endpackage

// File: rtl/uart_move_tx.sv
// Framed move transmitter: latches one move, then writes SOF, piece/orient,
// x, y and checksum into the tx FIFO, pausing whenever the FIFO is full.
module uart_move_tx
  import uart_move_tx_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE  = MOVE_SOF_BYTE,
  parameter logic [7:0] PASS_BYTE = MOVE_PASS_BYTE,
  parameter int         COORD_W   = MOVE_COORD_W
) (
  input  logic               clk,
  input  logic               reset_pin,
  input  logic               move_valid,
  output logic               move_ready,
  input  logic [4:0]         move_piece,
  input  logic [2:0]         move_orient,
  input  logic [COORD_W-1:0] move_x,
  input  logic [COORD_W-1:0] move_y,
  input  logic               move_pass,
  input  logic               tx_full,
  output logic               wr_tx_pin,
  output logic [7:0]         w_data,
  output logic               busy
);

  tx_state_t  r_state;
  tx_state_t  w_state_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;
  logic [7:0] r_b1;
  logic [7:0] r_b2;
  logic [7:0] r_b3;
  logic [7:0] r_b4;
  logic       r_wr;
  logic       w_wr_nxt;
  logic [7:0] r_data;
  logic [7:0] w_data_nxt;
  logic       r_ready;
  logic       w_ready_nxt;
  logic       r_busy;
  logic       w_busy_nxt;
  logic       w_load;
  logic [7:0] w_new_b1;
  logic [7:0] w_new_b2;
  logic [7:0] w_new_b3;
  logic [7:0] w_cur_byte;

  // A pass overrides every field byte; coordinates are zero-extended.
  assign w_new_b1 = move_pass ? PASS_BYTE : {move_piece, move_orient};
  assign w_new_b2 = move_pass ? PASS_BYTE : 8'(move_x);
  assign w_new_b3 = move_pass ? PASS_BYTE : 8'(move_y);

  always_comb begin
    w_cur_byte = SOF_BYTE;
    case (r_cnt)
      IDX_SOF:   w_cur_byte = SOF_BYTE;
      IDX_PIECE: w_cur_byte = r_b1;
      IDX_X:     w_cur_byte = r_b2;
      IDX_Y:     w_cur_byte = r_b3;
      IDX_CHK:   w_cur_byte = r_b4;
      default:   w_cur_byte = SOF_BYTE;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_nxt    = 1'b0;
    w_data_nxt  = r_data;
    w_ready_nxt = r_ready;
    w_busy_nxt  = r_busy;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        if (move_valid && r_ready) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SEND;
          w_cnt_nxt   = 3'd0;
          w_ready_nxt = 1'b0;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        w_ready_nxt = 1'b0;
        w_busy_nxt  = 1'b1;
        // Backpressure freezes the counter so no byte is skipped or repeated.
        if (!tx_full) begin
          w_wr_nxt   = 1'b1;
          w_data_nxt = w_cur_byte;
          if (r_cnt == IDX_CHK) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 3'd0;
            w_ready_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end else begin
          w_wr_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 3'd0;
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_pin) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_wr    <= 1'b0;
      r_data  <= 8'h00;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wr    <= w_wr_nxt;
      r_data  <= w_data_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Checksum is formed once at latch time so the send path is a plain mux.
  always_ff @(posedge clk) begin
    if (reset_pin) begin
      r_b1 <= 8'h00;
      r_b2 <= 8'h00;
      r_b3 <= 8'h00;
      r_b4 <= 8'h00;
    end else if (w_load) begin
      r_b1 <= w_new_b1;
      r_b2 <= w_new_b2;
      r_b3 <= w_new_b3;
      r_b4 <= pkt_checksum(w_new_b1, w_new_b2, w_new_b3);
    end else begin
      r_b1 <= r_b1;
      r_b2 <= r_b2;
      r_b3 <= r_b3;
      r_b4 <= r_b4;
    end
  end

  assign move_ready = r_ready;
  assign wr_tx_pin  = r_wr;
  assign w_data     = r_data;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_move_tx.sv
// Directed bench for uart_move_tx: table of moves with hand-computed packets,
// plus reset, backpressure, back-to-back and mid-packet reset sequences.
module tb_uart_move_tx;

  logic       clk;
  logic       reset_pin;
  logic       move_valid;
  logic       move_ready;
  logic [4:0] move_piece;
  logic [2:0] move_orient;
  logic [4:0] move_x;
  logic [4:0] move_y;
  logic       move_pass;
  logic       tx_full;
  logic       wr_tx_pin;
  logic [7:0] w_data;
  logic       busy;

  typedef struct {
    logic            pass;
    logic [4:0]      piece;
    logic [2:0]      orient;
    logic [4:0]      x;
    logic [4:0]      y;
    logic [4:0][7:0] exp;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] got_q[$];
  int         n_checks;
  int         n_fail;
  int         last_cycles;

  uart_move_tx dut (
    .clk        (clk),
    .reset_pin  (reset_pin),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .move_piece (move_piece),
    .move_orient(move_orient),
    .move_x     (move_x),
    .move_y     (move_y),
    .move_pass  (move_pass),
    .tx_full    (tx_full),
    .wr_tx_pin  (wr_tx_pin),
    .w_data     (w_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic pass, input logic [4:0] piece,
                              input logic [2:0] orient, input logic [4:0] x,
                              input logic [4:0] y, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4);
    vec_t v;
    v.pass = pass; v.piece = piece; v.orient = orient; v.x = x; v.y = y;
    v.exp = {b4, b3, b2, b1, b0};
    return v;
  endfunction

  task automatic drive_move(input vec_t v);
    move_pass   = v.pass;
    move_piece  = v.piece;
    move_orient = v.orient;
    move_x      = v.x;
    move_y      = v.y;
  endtask

  task automatic scramble();
    move_pass   = 1'($urandom_range(0, 1));
    move_piece  = 5'($urandom_range(0, 31));
    move_orient = 3'($urandom_range(0, 7));
    move_x      = 5'($urandom_range(0, 31));
    move_y      = 5'($urandom_range(0, 31));
  endtask

  // Offers one move, then gathers its writes; optional stall after byte stall_at.
  task automatic send_and_collect(input string tag, input vec_t v,
                                  input int stall_at, input int stall_len);
    int   waitc;
    int   cyc;
    int   stall_left;
    logic prev_full;
    drive_move(v);
    move_valid = 1'b1;
    waitc = 0;
    while (!move_ready && waitc < 20) begin
      tick();
      waitc++;
    end
    chk({tag, "_accept"}, 32'(move_ready), 32'd1);
    tick();
    move_valid = 1'b0;
    scramble();
    chk({tag, "_busy_after_xfer"}, 32'(busy), 32'd1);
    chk({tag, "_no_wr_xfer_cycle"}, 32'(wr_tx_pin), 32'd0);
    got_q.delete();
    cyc = 0;
    stall_left = 0;
    while (got_q.size() < 5 && cyc < 30) begin
      prev_full = tx_full;
      tick();
      cyc++;
      if (prev_full) begin
        stall_left--;
        if (stall_left <= 0) tx_full = 1'b0;
      end
      if (wr_tx_pin) begin
        chk({tag, "_no_wr_while_full"}, 32'(prev_full), 32'd0);
        got_q.push_back(w_data);
        if (stall_len > 0 && got_q.size() == stall_at + 1) begin
          tx_full = 1'b1;
          stall_left = stall_len;
        end
      end
    end
    last_cycles = cyc;
    chk({tag, "_nbytes"}, 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) chk($sformatf("%s_B%0d", tag, i), 32'(got_q[i]), 32'(v.exp[i]));
    end
    chk({tag, "_cycles"}, 32'(cyc), 32'(5 + stall_len));
    chk({tag, "_ready_after_B4"}, 32'(move_ready), 32'd1);
    tick();
    chk({tag, "_no_extra_wr"}, 32'(wr_tx_pin), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int   xfers;
    int   first_c;
    int   second_c;
    int   extra;
    logic take;

    n_checks = 0;
    n_fail = 0;
    reset_pin = 1'b1;
    move_valid = 1'b0;
    tx_full = 1'b0;
    move_pass = 1'b0;
    move_piece = 5'd0;
    move_orient = 3'd0;
    move_x = 5'd0;
    move_y = 5'd0;

    vecs[0] = mk(1'b0, 5'd7,  3'd3, 5'd4,  5'd9,  8'hA5, 8'h3B, 8'h04, 8'h09, 8'h36);
    vecs[1] = mk(1'b1, 5'd3,  3'd1, 5'd2,  5'd3,  8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    vecs[2] = mk(1'b0, 5'd20, 3'd7, 5'd31, 5'd0,  8'hA5, 8'hA7, 8'h1F, 8'h00, 8'hB8);
    vecs[3] = mk(1'b0, 5'd0,  3'd0, 5'd0,  5'd0,  8'hA5, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[4] = mk(1'b0, 5'd31, 3'd5, 5'd19, 5'd13, 8'hA5, 8'hFD, 8'h13, 8'h0D, 8'hE3);
    vecs[5] = mk(1'b0, 5'd1,  3'd2, 5'd10, 5'd21, 8'hA5, 8'h0A, 8'h0A, 8'h15, 8'h15);

    // Reset dominates a pending move.
    drive_move(vecs[0]);
    move_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_ready", 32'(move_ready), 32'd1);
      chk("rst_wr", 32'(wr_tx_pin), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_data", 32'(w_data), 32'h00);
    end
    move_valid = 1'b0;
    reset_pin = 1'b0;
    tick();
    chk("post_rst_ready", 32'(move_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) begin
      send_and_collect($sformatf("vec%0d", i), vecs[i], -1, 0);
    end

    send_and_collect("bp", vecs[0], 1, 4);

    // Move B is presented right after A is taken; valid stays high throughout.
    drive_move(vecs[0]);
    move_valid = 1'b1;
    got_q.delete();
    xfers = 0;
    first_c = -1;
    second_c = -1;
    for (int c = 0; c < 16; c++) begin
      take = move_valid && move_ready;
      tick();
      if (wr_tx_pin) got_q.push_back(w_data);
      if (take) begin
        xfers++;
        if (xfers == 1) begin
          first_c = c;
          drive_move(vecs[2]);
        end else begin
          second_c = c;
          move_valid = 1'b0;
        end
      end
    end
    move_valid = 1'b0;
    chk("b2b_xfers", 32'(xfers), 32'd2);
    chk("b2b_spacing", 32'(second_c - first_c), 32'd6);
    chk("b2b_nbytes", 32'(got_q.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < got_q.size())
        chk($sformatf("b2b_B%0d", i), 32'(got_q[i]),
            32'(i < 5 ? vecs[0].exp[i] : vecs[2].exp[i-5]));
    end

    // Reset once three bytes are out; nothing more may follow.
    drive_move(vecs[4]);
    move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    got_q.delete();
    for (int c = 0; c < 10 && got_q.size() < 3; c++) begin
      tick();
      if (wr_tx_pin) got_q.push_back(w_data);
    end
    chk("mid_nbytes_before_rst", 32'(got_q.size()), 32'd3);
    reset_pin = 1'b1;
    tick();
    chk("mid_rst_wr", 32'(wr_tx_pin), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(move_ready), 32'd1);
    reset_pin = 1'b0;
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (wr_tx_pin) extra++;
    end
    chk("mid_no_writes_after_rst", 32'(extra), 32'd0);
    send_and_collect("fresh", vecs[0], -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
